// File: rtl/dff_array.sv
// dff_array: WIDTH independent DEPTH-stage enable flops with per-channel set/reset and a stage-0 change counter.
// Defining DFF_ARRAY_PARITY_EN adds the registered parity output q_par.
module dff_array #(
  parameter int                 WIDTH  = 8,
  parameter int                 DEPTH  = 1,
  parameter logic [WIDTH-1:0]   EN_INV = '0,
  parameter logic [WIDTH-1:0]   SR_INV = '0,
  parameter logic [WIDTH-1:0]   SR_VAL = '0,
  parameter logic [WIDTH-1:0]   INIT   = '0,
  parameter logic [2*WIDTH-1:0] SR_SEL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             sr,
  input  logic [WIDTH-1:0] sr_vec,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [15:0]      chg_cnt
`ifdef DFF_ARRAY_PARITY_EN
  ,
  output logic             q_par
`endif
);

  logic [WIDTH-1:0]            en_ch;
  logic [WIDTH-1:0]            sr_src;
  logic [WIDTH-1:0]            sr_ch;
  logic [DEPTH-1:0][WIDTH-1:0] stg;
  logic [DEPTH-1:0][WIDTH-1:0] shift_in;
  logic [DEPTH-1:0][WIDTH-1:0] stg_nxt;
  logic                        stg0_chg;

  always_comb begin
    sr_src = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (SR_SEL[2*i +: 2])
        2'd0:    sr_src[i] = 1'b0;
        2'd1:    sr_src[i] = 1'b1;
        2'd2:    sr_src[i] = sr;
        default: sr_src[i] = sr_vec[i];
      endcase
    end
  end

  assign en_ch = {WIDTH{en}} ^ EN_INV;
  assign sr_ch = sr_src ^ SR_INV;

  // Stage 0 shifts from d, every later stage from its predecessor.
  always_comb begin
    shift_in    = '0;
    shift_in[0] = d;
    for (int k = 1; k < DEPTH; k++) begin
      shift_in[k] = stg[k-1];
    end
  end

  always_comb begin
    stg_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stg_nxt[k] = (sr_ch & SR_VAL)
                 | (~sr_ch & en_ch & shift_in[k])
                 | (~sr_ch & ~en_ch & stg[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= {DEPTH{INIT}};
    end else begin
      stg <= stg_nxt;
    end
  end

  assign q        = stg[DEPTH-1];
  assign stg0_chg = (stg_nxt[0] != stg[0]);

  // Clear takes priority over a coincident increment; reset-driven changes never count.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      chg_cnt <= 16'd0;
    end else if (stg0_chg && (chg_cnt != 16'hFFFF)) begin
      chg_cnt <= chg_cnt + 16'd1;
    end
  end

`ifdef DFF_ARRAY_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      q_par <= ^INIT;
    end else begin
      q_par <= ^stg_nxt[DEPTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_dff_array.sv
// Bench for dff_array: hand table on a 4-bit single-stage instance, model-checked random and corner sequences on an 8-bit 3-stage instance.
module tb_dff_array;

  localparam logic [7:0]  A_EN_INV = 8'b1010_0000;
  localparam logic [7:0]  A_SR_INV = 8'b0100_1000;
  localparam logic [7:0]  A_SR_VAL = 8'b1100_0110;
  localparam logic [7:0]  A_INIT   = 8'b0011_1000;
  localparam logic [15:0] A_SR_SEL = 16'hCEE4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_rst, a_en, a_sr, a_clr;
  logic [7:0] a_d, a_sv, a_q;
  logic [15:0] a_cnt;
  logic       b_rst, b_en, b_sr, b_clr;
  logic [3:0] b_d, b_sv, b_q;
  logic [15:0] b_cnt;
`ifdef DFF_ARRAY_PARITY_EN
  logic a_par, b_par;
`endif

  dff_array #(
    .WIDTH(8), .DEPTH(3), .EN_INV(A_EN_INV), .SR_INV(A_SR_INV),
    .SR_VAL(A_SR_VAL), .INIT(A_INIT), .SR_SEL(A_SR_SEL)
  ) u_a (
    .clk(clk), .rst(a_rst), .d(a_d), .en(a_en), .sr(a_sr), .sr_vec(a_sv),
    .cnt_clr(a_clr), .q(a_q), .chg_cnt(a_cnt)
`ifdef DFF_ARRAY_PARITY_EN
    , .q_par(a_par)
`endif
  );

  dff_array #(
    .WIDTH(4), .DEPTH(1), .EN_INV(4'b0011), .SR_INV(4'b1000),
    .SR_VAL(4'b1001), .INIT(4'b1010), .SR_SEL(8'hAA)
  ) u_b (
    .clk(clk), .rst(b_rst), .d(b_d), .en(b_en), .sr(b_sr), .sr_vec(b_sv),
    .cnt_clr(b_clr), .q(b_q), .chg_cnt(b_cnt)
`ifdef DFF_ARRAY_PARITY_EN
    , .q_par(b_par)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model for u_a: each channel is a list of bits, index 0 nearest d.
  bit        mp [8][3];
  int        mcnt = 0;
  bit [7:0]  m_eninv = A_EN_INV;
  bit [7:0]  m_srinv = A_SR_INV;
  bit [7:0]  m_srval = A_SR_VAL;
  bit [7:0]  m_init  = A_INIT;
  int        sel_tab [8] = '{0, 1, 2, 3, 2, 3, 0, 3};

  function automatic logic [7:0] mq();
    logic [7:0] r;
    for (int ch = 0; ch < 8; ch++) r[ch] = mp[ch][2];
    return r;
  endfunction

  task automatic model_step(input bit r, input logic [7:0] dd, input bit e, input bit s,
                            input logic [7:0] sv, input bit c);
    bit changed = 1'b0;
    bit old0, src, act_sr, act_en;
    for (int ch = 0; ch < 8; ch++) begin
      old0 = mp[ch][0];
      case (sel_tab[ch])
        0:       src = 1'b0;
        1:       src = 1'b1;
        2:       src = s;
        default: src = sv[ch];
      endcase
      act_sr = src ^ m_srinv[ch];
      act_en = e ^ m_eninv[ch];
      if (r) begin
        for (int k = 0; k < 3; k++) mp[ch][k] = m_init[ch];
      end else if (act_sr) begin
        for (int k = 0; k < 3; k++) mp[ch][k] = m_srval[ch];
      end else if (act_en) begin
        for (int k = 2; k > 0; k--) mp[ch][k] = mp[ch][k-1];
        mp[ch][0] = dd[ch];
      end
      if (!r && (mp[ch][0] != old0)) changed = 1'b1;
    end
    if (r || c) mcnt = 0;
    else if (changed && mcnt < 65535) mcnt++;
  endtask

  task automatic tick_a(input bit r, input logic [7:0] dd, input bit e, input bit s,
                        input logic [7:0] sv, input bit c, input bit chk);
    a_rst = r; a_d = dd; a_en = e; a_sr = s; a_sv = sv; a_clr = c;
    model_step(r, dd, e, s, sv, c);
    @(posedge clk);
    #1;
    if (chk) begin
      check("a_q", 64'(a_q), 64'(mq()));
      check("a_cnt", 64'(a_cnt), 64'(mcnt));
`ifdef DFF_ARRAY_PARITY_EN
      check("a_par", 64'(a_par), 64'(^mq()));
`endif
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  d;
    logic        en;
    logic        sr;
    logic        clr;
    logic [3:0]  eq;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [12];

  initial begin
    a_rst = 0; a_d = 0; a_en = 0; a_sr = 0; a_sv = 0; a_clr = 0;
    b_rst = 0; b_d = 0; b_en = 0; b_sr = 0; b_sv = 0; b_clr = 0;

    //           rst d        en sr clr  q        cnt
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1010, 16'd0};
    tbl[1]  = '{1'b0, 4'b0101, 1'b1, 1'b1, 1'b0, 4'b0001, 16'd1};
    tbl[2]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b1011, 16'd2};
    tbl[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1000, 16'd3};
    tbl[4]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0001, 16'd4};
    tbl[5]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b1101, 16'd5};
    tbl[6]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b1101, 16'd5};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b1001, 16'd0};
    tbl[8]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b1010, 16'd0};
    tbl[9]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1010, 16'd0};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1000, 16'd1};
    tbl[11] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1001, 16'd2};

    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      b_rst = tbl[i].rst; b_d = tbl[i].d; b_en = tbl[i].en; b_sr = tbl[i].sr; b_clr = tbl[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_q", i), 64'(b_q), 64'(tbl[i].eq));
      check($sformatf("tbl%0d_cnt", i), 64'(b_cnt), 64'(tbl[i].ecnt));
`ifdef DFF_ARRAY_PARITY_EN
      check($sformatf("tbl%0d_par", i), 64'(b_par), 64'(^tbl[i].eq));
`endif
    end
    b_rst = 0; b_d = 0; b_en = 0; b_sr = 0; b_clr = 0;

    // Single pulse through three stages on plain channel 0.
    tick_a(1, 8'h00, 0, 0, 8'h00, 0, 1);
    check("rst_q", 64'(a_q), 64'h38);
    check("rst_cnt", 64'(a_cnt), 64'h0);
    tick_a(0, 8'h01, 1, 0, 8'h00, 0, 1);
    check("lat1", 64'(a_q[0]), 64'h0);
    tick_a(0, 8'h00, 1, 0, 8'h00, 0, 1);
    check("lat2", 64'(a_q[0]), 64'h0);
    tick_a(0, 8'h00, 1, 0, 8'h00, 0, 1);
    check("lat3", 64'(a_q[0]), 64'h1);
    tick_a(0, 8'h00, 1, 0, 8'h00, 0, 1);
    check("lat4", 64'(a_q[0]), 64'h0);

    // Reset in the middle of the shift discards the pulse.
    tick_a(0, 8'h01, 1, 0, 8'h00, 0, 1);
    tick_a(1, 8'h00, 1, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick_a(0, 8'h00, 1, 0, 8'h00, 0, 1);
      check($sformatf("midrst%0d", i), 64'(a_q[0]), 64'h0);
    end

    // Latency counts enabled cycles only.
    tick_a(0, 8'h01, 1, 0, 8'h00, 0, 1);
    tick_a(0, 8'h00, 0, 0, 8'h00, 0, 1);
    tick_a(0, 8'h00, 1, 0, 8'h00, 0, 1);
    tick_a(0, 8'h00, 0, 0, 8'h00, 0, 1);
    check("gap_hold", 64'(a_q[0]), 64'h0);
    tick_a(0, 8'h00, 1, 0, 8'h00, 0, 1);
    check("gap_out", 64'(a_q[0]), 64'h1);

    for (int i = 0; i < 1000; i++) begin
      tick_a($urandom_range(0, 49) == 0, 8'($urandom), 1'($urandom), 1'($urandom),
             8'($urandom), $urandom_range(0, 29) == 0, 1);
    end

    // Saturation: channel 0 toggles every enabled cycle.
    tick_a(1, 8'h00, 0, 0, 8'h00, 0, 1);
    for (int n = 1; n <= 65534; n++) begin
      tick_a(0, (n % 2) ? 8'hFF : 8'h00, 1, 0, 8'h00, 0, 0);
    end
    check("sat_m1", 64'(a_cnt), 64'hFFFE);
    for (int n = 65535; n <= 65540; n++) begin
      tick_a(0, (n % 2) ? 8'hFF : 8'h00, 1, 0, 8'h00, 0, 0);
    end
    check("sat_hold", 64'(a_cnt), 64'hFFFF);
    check("sat_model", 64'(a_cnt), 64'(mcnt));
    tick_a(0, 8'hFF, 1, 0, 8'h00, 1, 1);
    check("clr_wins", 64'(a_cnt), 64'h0);
    tick_a(0, 8'h00, 1, 0, 8'h00, 0, 1);
    check("after_clr", 64'(a_cnt), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
